// File: rtl/chacha_pkg.sv
// Shared ChaCha types: 32-bit word, keystream block size and the keystream-buffer FSM states.
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned KS_WORDS = 16;
  localparam int unsigned KS_ROWS  = 4;
  localparam int unsigned WIDX_W   = 4;

  typedef logic [WIDX_W-1:0] widx_t;

  localparam widx_t LAST_WIDX = widx_t'(KS_WORDS - 1);

  typedef enum logic {
    StEmpty,
    StFull
  } ks_state_e;

  // Zero every byte whose keep bit is clear.
  function automatic word_t keep_mask(word_t w, logic [3:0] keep);
    word_t r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = keep[b] ? w[8*b +: 8] : 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/keystream_xor.sv
// Buffers one 16-word keystream block and XORs it onto a plaintext word stream,
// producing a registered ciphertext stream with valid/ready handshaking.
module keystream_xor
  import chacha_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  word_t [3:0][3:0]     ks_in,
  input  logic                 ks_valid,
  output logic                 ks_req,
  input  logic [31:0]          pt_data,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic                 pt_last,
  input  logic [3:0]           pt_keep,
  output logic [31:0]          ct_data,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic                 ct_last,
  output logic [3:0]           ct_keep,
  input  logic                 flush,
  output logic [CNT_W-1:0]     block_count,
  output logic                 err
);

  ks_state_e        state_q, state_d;
  widx_t            widx_q, widx_d;
  logic [CNT_W-1:0] block_count_q, block_count_d;
  logic             err_q, err_d;
  logic             ks_prev_q, ks_prev_d;
  word_t            buf_q [KS_WORDS];
  word_t            buf_d [KS_WORDS];
  logic [31:0]      ct_data_q, ct_data_d;
  logic             ct_valid_q, ct_valid_d;
  logic             ct_last_q, ct_last_d;
  logic [3:0]       ct_keep_q, ct_keep_d;

  logic  full;
  logic  ks_rise;
  logic  xfer;
  word_t ks_word;

  assign full     = (state_q == StFull);
  assign ks_rise  = ks_valid & ~ks_prev_q;
  assign pt_ready = full & (~ct_valid_q | ct_ready);
  // A flush in the same cycle suppresses the transfer even though pt_ready is high.
  assign xfer     = pt_valid & pt_ready & ~flush;
  assign ks_word  = buf_q[widx_q];

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    block_count_d = block_count_q;
    err_d         = err_q;
    ks_prev_d     = ks_valid;
    buf_d         = buf_q;

    if (full) begin
      if (ks_rise) begin
        err_d = 1'b1;
      end
      if (flush) begin
        state_d = StEmpty;
        widx_d  = '0;
      end else if (xfer) begin
        widx_d = widx_q + widx_t'(1);
        if (pt_last || (widx_q == LAST_WIDX)) begin
          state_d = StEmpty;
          widx_d  = '0;
        end
      end
    end else if (ks_rise) begin
      for (int r = 0; r < KS_ROWS; r++) begin
        for (int c = 0; c < KS_ROWS; c++) begin
          buf_d[r*KS_ROWS + c] = ks_in[r][c];
        end
      end
      state_d       = StFull;
      widx_d        = '0;
      block_count_d = block_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    ct_data_d  = ct_data_q;
    ct_valid_d = ct_valid_q;
    ct_last_d  = ct_last_q;
    ct_keep_d  = ct_keep_q;
    if (xfer) begin
      ct_data_d  = keep_mask(pt_data ^ ks_word, pt_keep);
      ct_valid_d = 1'b1;
      ct_last_d  = pt_last;
      ct_keep_d  = pt_keep;
    end else if (ct_ready) begin
      ct_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StEmpty;
      widx_q        <= '0;
      block_count_q <= '0;
      err_q         <= 1'b0;
      ks_prev_q     <= 1'b0;
      buf_q         <= '{default: '0};
      ct_data_q     <= '0;
      ct_valid_q    <= 1'b0;
      ct_last_q     <= 1'b0;
      ct_keep_q     <= '0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      block_count_q <= block_count_d;
      err_q         <= err_d;
      ks_prev_q     <= ks_prev_d;
      buf_q         <= buf_d;
      ct_data_q     <= ct_data_d;
      ct_valid_q    <= ct_valid_d;
      ct_last_q     <= ct_last_d;
      ct_keep_q     <= ct_keep_d;
    end
  end

  assign ks_req      = ~full;
  assign ct_data     = ct_data_q;
  assign ct_valid    = ct_valid_q;
  assign ct_last     = ct_last_q;
  assign ct_keep     = ct_keep_q;
  assign block_count = block_count_q;
  assign err         = err_q;

endmodule
